cmd_feeder: RTL and testbench
=============================

CMD_FEEDER -- requirements
Module: cmd_feeder

Interface
REQ-001 Parameters (name, default, meaning): FIFO_DEPTH, 4, command buffer entries; STK_DEPTH, 8, capacity of the downstream stack being modelled.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  producer offers a command.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  3  command opcode (3'b101 = PUSH, 3'b000 = POP, any other value = OTHER).
REQ-007 cmd_data  input  8  push operand.
REQ-008 stall  input  1  downstream hold; no command is issued while high.
REQ-009 out_op  output  3  registered opcode to the stack stage's op port.
REQ-010 out_data  output  8  registered operand to the stack stage's in port.
REQ-011 apply  output  1  registered one-cycle strobe qualifying out_op/out_data.
REQ-012 rejected  output  1  registered one-cycle pulse: head command dropped.
REQ-013 level  output  4  modelled downstream stack occupancy, 0..STK_DEPTH.

Function
REQ-014 The block SHALL hold a FIFO of FIFO_DEPTH entries of {op[2:0], data[7:0]} with wrap-around read and write pointers and an occupancy count 0..FIFO_DEPTH.
REQ-015 cmd_ready SHALL be combinational: 1 when rst=0 and FIFO count < FIFO_DEPTH, else 0; it SHALL NOT depend on a same-cycle issue (no full-bypass).
REQ-016 A command SHALL be written when cmd_valid && cmd_ready at a rising edge; cmd_valid with cmd_ready=0 SHALL be ignored, with no state change.
REQ-017 Issue decision at each edge: if FIFO non-empty and stall=0, the head entry SHALL be popped and classified; otherwise apply=0 and rejected=0 for the next cycle, with out_op/out_data holding their last values.
REQ-018 Head PUSH with level==STK_DEPTH, or head POP with level==0: the entry SHALL be popped, apply=0, rejected=1 for one cycle, level unchanged.
REQ-019 Otherwise the entry SHALL be issued: out_op/out_data load the head fields, apply=1 for one cycle, rejected=0.
REQ-020 Issued PUSH SHALL increment level; issued POP SHALL decrement level; issued OTHER SHALL leave level unchanged and is never rejected.
REQ-021 At most one entry SHALL be popped per cycle; sustained throughput is one command per cycle.
REQ-022 Latency: a command written at edge N into an empty FIFO SHALL appear with apply=1 (or rejected=1) after edge N+1; no same-edge bypass.
REQ-023 Simultaneous write and pop in one edge SHALL leave the FIFO count unchanged and preserve order.
REQ-024 Classification SHALL use level as registered before the edge, so back-to-back PUSHes each observe the level updated by their predecessor.

Reset
REQ-025 While rst=1 at an edge: FIFO count=0, pointers=0, out_op=3'b000, out_data=8'h00, apply=0, rejected=0, level=0; cmd_ready=0 during rst.
REQ-026 rst asserted mid-stream SHALL discard all buffered commands; no apply occurs on the edge following a reset edge.
REQ-027 The first command may be accepted at the first edge with rst=0.

Verification
REQ-028 Reset then PUSH 8'h01, 8'h02, 8'h09 on consecutive cycles, stall=0 -> apply=1 for three consecutive cycles starting one cycle after the first acceptance, out_data 01,02,09, out_op 101, level ends at 3.
REQ-029 From reset, POP -> rejected=1 for one cycle, apply=0, level stays 0; following PUSH 8'h04 -> apply=1, level=1.
REQ-030 stall=1, offer 5 commands -> 4 accepted, cmd_ready=0 on the 5th, which is held; release stall -> issued in order one per cycle, 5th accepted once space frees.
REQ-031 Nine PUSHes from empty -> first eight issued (level=8), ninth rejected; then POP -> issued, level=7.
REQ-032 OTHER op 3'b110 with level=0 -> issued with apply=1, out_op=110, level unchanged.
REQ-033 Assert rst for one cycle with 3 entries buffered -> apply=0, level=0, cmd_ready=1 on the cycle after reset releases; no buffered command ever issued.

Source files
------------

// File: rtl/cmd_feeder.sv
// Command feeder: buffers producer commands in a small FIFO and issues them to a
// downstream stack stage, dropping PUSH-when-full / POP-when-empty against a modelled level.
module cmd_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int STK_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       stall,
    output logic [2:0] out_op,
    output logic [7:0] out_data,
    output logic       apply,
    output logic       rejected,
    output logic [3:0] level
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b000;

    logic [10:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       out_op_q, out_op_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             apply_q, apply_d;
    logic             rejected_q, rejected_d;
    logic [3:0]       level_q, level_d;

    logic       push_en;
    logic       pop_en;
    logic       drop;
    logic [2:0] head_op;
    logic [7:0] head_data;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready reflects only the registered count, so a full FIFO never accepts
    // even if an entry leaves on the same edge.
    assign cmd_ready = !rst && (cnt_q < CNT_W'(FIFO_DEPTH));
    assign push_en   = cmd_valid && cmd_ready;
    assign pop_en    = (cnt_q != '0) && !stall;

    assign head_op   = mem_q[rd_ptr_q][10:8];
    assign head_data = mem_q[rd_ptr_q][7:0];

    // Classification uses the pre-edge level so consecutive pushes chain correctly.
    assign drop = ((head_op == OP_PUSH) && (level_q == 4'(STK_DEPTH))) ||
                  ((head_op == OP_POP)  && (level_q == 4'd0));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        out_op_d   = out_op_q;
        out_data_d = out_data_q;
        apply_d    = 1'b0;
        rejected_d = 1'b0;
        level_d    = level_q;

        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (drop) begin
                rejected_d = 1'b1;
            end else begin
                apply_d    = 1'b1;
                out_op_d   = head_op;
                out_data_d = head_data;
                if (head_op == OP_PUSH) begin
                    level_d = level_q + 4'd1;
                end else if (head_op == OP_POP) begin
                    level_d = level_q - 4'd1;
                end
            end
        end

        if (push_en && !pop_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_en && pop_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            out_op_q   <= 3'b000;
            out_data_q <= 8'h00;
            apply_q    <= 1'b0;
            rejected_q <= 1'b0;
            level_q    <= 4'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            out_op_q   <= out_op_d;
            out_data_q <= out_data_d;
            apply_q    <= apply_d;
            rejected_q <= rejected_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_data};
        end
    end

    assign out_op   = out_op_q;
    assign out_data = out_data_q;
    assign apply    = apply_q;
    assign rejected = rejected_q;
    assign level    = level_q;

endmodule

// File: tb/tb_cmd_feeder.sv
// Bench for cmd_feeder: directed scenarios plus random traffic, each cycle checked
// against a queue-based model of the command buffer and the downstream stack level.
module tb_cmd_feeder;

    localparam int FIFO_DEPTH = 4;
    localparam int STK_DEPTH  = 8;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       stall;
    logic [2:0] out_op;
    logic [7:0] out_data;
    logic       apply;
    logic       rejected;
    logic [3:0] level;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [10:0] exp_q[$];
    int          m_level = 0;
    logic        m_apply = 1'b0;
    logic        m_rej   = 1'b0;
    logic [2:0]  m_op    = 3'b000;
    logic [7:0]  m_data  = 8'h00;

    cmd_feeder #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .STK_DEPTH (STK_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .stall    (stall),
        .out_op   (out_op),
        .out_data (out_data),
        .apply    (apply),
        .rejected (rejected),
        .level    (level)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model of one clock edge, from the block's rules rather than its registers
    task automatic model_edge(input logic v, input logic [2:0] op, input logic [7:0] d,
                              input logic st, input logic r, output logic acc);
        logic [10:0] head;
        logic        rdy;
        acc = 1'b0;
        if (r) begin
            exp_q.delete();
            m_level = 0;
            m_apply = 1'b0;
            m_rej   = 1'b0;
            m_op    = 3'b000;
            m_data  = 8'h00;
        end else begin
            rdy     = (exp_q.size() < FIFO_DEPTH);
            m_apply = 1'b0;
            m_rej   = 1'b0;
            if (exp_q.size() > 0 && !st) begin
                head = exp_q.pop_front();
                if ((head[10:8] == 3'b101 && m_level == STK_DEPTH) ||
                    (head[10:8] == 3'b000 && m_level == 0)) begin
                    m_rej = 1'b1;
                end else begin
                    m_apply = 1'b1;
                    m_op    = head[10:8];
                    m_data  = head[7:0];
                    if (head[10:8] == 3'b101) m_level++;
                    else if (head[10:8] == 3'b000) m_level--;
                end
            end
            if (v && rdy) begin
                exp_q.push_back({op, d});
                acc = 1'b1;
            end
        end
    endtask

    // Driver: one full cycle with checks before and after the edge
    task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] d,
                         input logic st, input logic r, output logic acc);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        stall     = st;
        rst       = r;
        #1;
        check_eq("cmd_ready", {31'b0, cmd_ready}, {31'b0, (!r && exp_q.size() < FIFO_DEPTH)});
        model_edge(v, op, d, st, r, acc);
        @(posedge clk);
        #1;
        check_eq("apply",    {31'b0, apply},    {31'b0, m_apply});
        check_eq("rejected", {31'b0, rejected}, {31'b0, m_rej});
        check_eq("level",    {28'b0, level},    32'(m_level));
        check_eq("out_op",   {29'b0, out_op},   {29'b0, m_op});
        check_eq("out_data", {24'b0, out_data}, {24'b0, m_data});
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 3'b111, 8'h00, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        cycle(1'b0, 3'b000, 8'h00, 1'b0, 1'b1, acc);
    endtask

    // Holds a command offered until it is accepted, with a bounded wait
    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic st);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, op, d, st, 1'b0, acc);
            n++;
        end
        check_eq("send_accepted", {31'b0, acc}, 32'd1);
    endtask

    initial begin
        logic acc;
        logic [7:0] seq_a [3];
        seq_a = '{8'h01, 8'h02, 8'h09};
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 8'h00;
        stall     = 1'b0;
        rst       = 1'b1;

        do_reset();
        do_reset();

        // Three pushes back to back
        for (int i = 0; i < 3; i++) send(3'b101, seq_a[i], 1'b0);
        idle(3);
        check_eq("seq_level", {28'b0, level}, 32'd3);

        // Pop from empty is dropped, then a push is issued
        do_reset();
        send(3'b000, 8'h00, 1'b0);
        idle(1);
        check_eq("pop_empty_level", {28'b0, level}, 32'd0);
        send(3'b101, 8'h04, 1'b0);
        idle(2);
        check_eq("push_after_level", {28'b0, level}, 32'd1);

        // Fill under stall, fifth held until space frees
        do_reset();
        for (int i = 0; i < 4; i++) send(3'b101, 8'h10 + 8'(i), 1'b1);
        cycle(1'b1, 3'b101, 8'h14, 1'b1, 1'b0, acc);
        check_eq("full_not_accepted", {31'b0, acc}, 32'd0);
        send(3'b101, 8'h14, 1'b0);
        idle(6);
        check_eq("stall_level", {28'b0, level}, 32'd5);

        // Nine pushes: stack overflows on the ninth, then a pop
        do_reset();
        for (int i = 0; i < 9; i++) send(3'b101, 8'h20 + 8'(i), 1'b0);
        idle(2);
        check_eq("full_level", {28'b0, level}, 32'd8);
        send(3'b000, 8'h00, 1'b0);
        idle(2);
        check_eq("pop_full_level", {28'b0, level}, 32'd7);

        // Other opcode with empty stack
        do_reset();
        send(3'b110, 8'h5a, 1'b0);
        idle(1);
        check_eq("other_op", {29'b0, out_op}, 32'd6);
        check_eq("other_level", {28'b0, level}, 32'd0);

        // Reset mid-stream discards buffered commands
        do_reset();
        for (int i = 0; i < 3; i++) send(3'b101, 8'h30 + 8'(i), 1'b1);
        do_reset();
        idle(3);
        check_eq("flush_level", {28'b0, level}, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? 3'b101 : (sel < 8) ? 3'b000 : 3'($urandom_range(1, 7));
            cycle($urandom_range(0, 3) != 0, op, 8'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 199) == 0, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
